// File: rtl/mac3_driver.sv
// Sequencer feeding a three-lane MAC: streams operand beats of one job into the MAC,
// waits out the MAC pipeline, captures the scaled result and offers it on a handshake.
module mac3_driver #(
    parameter int unsigned A_WIDTH           = 16,
    parameter int unsigned B_WIDTH           = 16,
    parameter int unsigned ACCUMULATOR_WIDTH = 32,
    parameter int unsigned OUTPUT_WIDTH      = 16,
    parameter int unsigned CNT_WIDTH         = 8
) (
    input  logic                         clk,
    input  logic                         arst_in,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         cfg_len,
    input  logic                         cfg_seed_en,
    input  logic [ACCUMULATOR_WIDTH-1:0] cfg_seed,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [A_WIDTH-1:0]           op_a0,
    input  logic [A_WIDTH-1:0]           op_a1,
    input  logic [A_WIDTH-1:0]           op_a2,
    input  logic [B_WIDTH-1:0]           op_b0,
    input  logic [B_WIDTH-1:0]           op_b1,
    input  logic [B_WIDTH-1:0]           op_b2,
    output logic                         mac_input_valid,
    output logic                         mac_accumulate_internal,
    output logic [ACCUMULATOR_WIDTH-1:0] mac_partial_sum_in,
    output logic [A_WIDTH-1:0]           mac_a0,
    output logic [A_WIDTH-1:0]           mac_a1,
    output logic [A_WIDTH-1:0]           mac_a2,
    output logic [B_WIDTH-1:0]           mac_b0,
    output logic [B_WIDTH-1:0]           mac_b1,
    output logic [B_WIDTH-1:0]           mac_b2,
    input  logic [OUTPUT_WIDTH-1:0]      mac_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [OUTPUT_WIDTH-1:0]      res_data,
    output logic                         busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DRAIN   = 3'd2,
        CAPTURE = 3'd3,
        RESULT  = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 accept;
    logic                 beat_hs;
    logic                 last_beat;
    logic                 capture;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic [CNT_WIDTH-1:0] len_q;

    // Next-state decode plus the single-cycle strobes that steer the datapath registers.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        beat_hs   = 1'b0;
        last_beat = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (cfg_len != '0)) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                beat_hs   = op_valid && op_ready;
                last_beat = (beat_cnt == (len_q - CNT_WIDTH'(1)));
                if (beat_hs && last_beat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            op_ready        <= 1'b0;
            busy            <= 1'b0;
            res_valid       <= 1'b0;
            mac_input_valid <= 1'b0;
        end else begin
            op_ready        <= (state_d == RUN);
            busy            <= (state_d != IDLE);
            res_valid       <= (state_d == RESULT);
            mac_input_valid <= beat_hs;
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            len_q              <= '0;
            beat_cnt           <= '0;
            mac_partial_sum_in <= '0;
        end else if (accept) begin
            len_q              <= cfg_len;
            beat_cnt           <= '0;
            mac_partial_sum_in <= cfg_seed_en ? cfg_seed : '0;
        end else if (beat_hs) begin
            beat_cnt           <= beat_cnt + CNT_WIDTH'(1);
        end
    end

    // Operands and accumulate select only move on a beat handshake and hold otherwise.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            mac_accumulate_internal <= 1'b0;
            mac_a0                  <= '0;
            mac_a1                  <= '0;
            mac_a2                  <= '0;
            mac_b0                  <= '0;
            mac_b1                  <= '0;
            mac_b2                  <= '0;
        end else if (beat_hs) begin
            mac_accumulate_internal <= (beat_cnt != '0);
            mac_a0                  <= op_a0;
            mac_a1                  <= op_a1;
            mac_a2                  <= op_a2;
            mac_b0                  <= op_b0;
            mac_b1                  <= op_b1;
            mac_b2                  <= op_b2;
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            res_data <= '0;
        end else if (capture) begin
            res_data <= mac_out;
        end
    end

endmodule

// File: tb/tb_mac3_driver.sv
// Directed bench for mac3_driver with a behavioural three-lane MAC (scale 0) closing the loop.
module tb_mac3_driver;

    localparam int unsigned AW           = 16;
    localparam int unsigned BW           = 16;
    localparam int unsigned ACW          = 32;
    localparam int unsigned OW           = 16;
    localparam int unsigned CW           = 8;
    localparam int unsigned OUTPUT_SCALE = 0;

    logic           clk = 1'b0;
    logic           arst_in;
    logic           start;
    logic [CW-1:0]  cfg_len;
    logic           cfg_seed_en;
    logic [ACW-1:0] cfg_seed;
    logic           op_valid;
    logic           op_ready;
    logic [AW-1:0]  op_a0, op_a1, op_a2;
    logic [BW-1:0]  op_b0, op_b1, op_b2;
    logic           mac_input_valid;
    logic           mac_accumulate_internal;
    logic [ACW-1:0] mac_partial_sum_in;
    logic [AW-1:0]  mac_a0, mac_a1, mac_a2;
    logic [BW-1:0]  mac_b0, mac_b1, mac_b2;
    logic [OW-1:0]  mac_out;
    logic           res_valid;
    logic           res_ready;
    logic [OW-1:0]  res_data;
    logic           busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac3_driver #(
        .A_WIDTH(AW), .B_WIDTH(BW), .ACCUMULATOR_WIDTH(ACW),
        .OUTPUT_WIDTH(OW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .arst_in(arst_in), .start(start), .cfg_len(cfg_len),
        .cfg_seed_en(cfg_seed_en), .cfg_seed(cfg_seed),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a0(op_a0), .op_a1(op_a1), .op_a2(op_a2),
        .op_b0(op_b0), .op_b1(op_b1), .op_b2(op_b2),
        .mac_input_valid(mac_input_valid),
        .mac_accumulate_internal(mac_accumulate_internal),
        .mac_partial_sum_in(mac_partial_sum_in),
        .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2),
        .mac_b0(mac_b0), .mac_b1(mac_b1), .mac_b2(mac_b2),
        .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy)
    );

    // Behavioural MAC: one-cycle registered accumulator, output is the truncated scaled sum.
    logic signed [ACW-1:0] acc;
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            acc <= '0;
        end else if (mac_input_valid) begin
            acc <= (mac_accumulate_internal ? acc : $signed(mac_partial_sum_in))
                 + $signed(mac_a0) * $signed(mac_b0)
                 + $signed(mac_a1) * $signed(mac_b1)
                 + $signed(mac_a2) * $signed(mac_b2);
        end
    end
    assign mac_out = OW'(acc >>> OUTPUT_SCALE);

    int             cyc = 0;
    int             hs_q[$];
    int             miv_cyc_q[$];
    bit             miv_acc_q[$];
    logic [ACW-1:0] psum_seen;
    int             rv_count = 0;
    int             rv_rise = -1;
    logic           rv_prev = 1'b0;

    // Event log sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (op_valid && op_ready) hs_q.push_back(cyc);
            if (mac_input_valid) begin
                miv_cyc_q.push_back(cyc);
                miv_acc_q.push_back(mac_accumulate_internal);
                psum_seen = mac_partial_sum_in;
            end
            if (res_valid && !rv_prev) begin
                rv_rise  = cyc;
                rv_count = rv_count + 1;
            end
            rv_prev = res_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        hs_q.delete();
        miv_cyc_q.delete();
        miv_acc_q.delete();
        rv_rise   = -1;
        psum_seen = 'x;
    endtask

    task automatic start_job(input logic [CW-1:0] len, input logic se, input logic [ACW-1:0] seed);
        cfg_len     = len;
        cfg_seed_en = se;
        cfg_seed    = seed;
        start       = 1'b1;
        cyc_wait();
        start       = 1'b0;
    endtask

    task automatic send_beat(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                             input logic [BW-1:0] b0, input logic [BW-1:0] b1, input logic [BW-1:0] b2);
        int n;
        n = 0;
        op_a0 = a0; op_a1 = a1; op_a2 = a2;
        op_b0 = b0; op_b1 = b1; op_b2 = b2;
        op_valid = 1'b1;
        while (!op_ready && n < 20) begin
            cyc_wait();
            n++;
        end
        check("op_ready_wait", 32'(op_ready), 32'd1);
        cyc_wait();
        op_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            cyc_wait();
            n++;
        end
        check("res_valid_wait", 32'(res_valid), 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic check_latency(input string tag);
        int lat;
        lat = (hs_q.size() > 0) ? (rv_rise - hs_q[hs_q.size()-1]) : -99;
        check(tag, 32'(lat), 32'd3);
    endtask

    task automatic finish_result();
        res_ready = 1'b1;
        cyc_wait();
        res_ready = 1'b0;
        check("res_valid_drop", 32'(res_valid), 32'd0);
        check("busy_drop", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rv_before;
        arst_in = 1'b1; start = 1'b0; cfg_len = '0; cfg_seed_en = 1'b0; cfg_seed = '0;
        op_valid = 1'b0; res_ready = 1'b0;
        op_a0 = '0; op_a1 = '0; op_a2 = '0; op_b0 = '0; op_b1 = '0; op_b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_miv", 32'(mac_input_valid), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        arst_in = 1'b0;
        cyc_wait();

        // len=1, no seed
        clear_log();
        start_job(8'd1, 1'b0, 32'd0);
        send_beat(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
        wait_result();
        check("t1_res_data", 32'(res_data), 32'd32);
        check_latency("t1_latency");
        check("t1_miv_count", 32'(miv_acc_q.size()), 32'd1);
        if (miv_acc_q.size() > 0) check("t1_acc_int", 32'(miv_acc_q[0]), 32'd0);
        check("t1_psum", psum_seen, 32'd0);
        finish_result();

        // len=1, seeded
        clear_log();
        start_job(8'd1, 1'b1, 32'd100);
        send_beat(16'd2, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0);
        wait_result();
        check("t2_res_data", 32'(res_data), 32'd106);
        check("t2_psum", psum_seen, 32'd100);
        check_latency("t2_latency");
        finish_result();

        // len=3 with two idle cycles between beats and a stray start mid-job
        clear_log();
        start_job(8'd3, 1'b0, 32'd0);
        for (int b = 0; b < 3; b++) begin
            if (b > 0) begin
                cfg_len = 8'd7; cfg_seed_en = 1'b1; cfg_seed = 32'd999;
                start = 1'b1;
                cyc_wait();
                start = 1'b0;
                cyc_wait();
            end
            send_beat(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
        end
        wait_result();
        check("t3_res_data", 32'(res_data), 32'd9);
        check("t3_miv_count", 32'(miv_acc_q.size()), 32'd3);
        n = (miv_acc_q.size() < hs_q.size()) ? miv_acc_q.size() : hs_q.size();
        for (int i = 0; i < n && i < 3; i++) begin
            check($sformatf("t3_acc_int%0d", i), 32'(miv_acc_q[i]), (i == 0) ? 32'd0 : 32'd1);
            check($sformatf("t3_miv_after_hs%0d", i), 32'(miv_cyc_q[i] - hs_q[i]), 32'd1);
        end
        check("t3_psum", psum_seen, 32'd0);
        finish_result();

        // len=2 negative result, back-pressured for five cycles
        clear_log();
        start_job(8'd2, 1'b0, 32'd0);
        send_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd5, 16'd5, 16'd5);
        send_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd5, 16'd5, 16'd5);
        wait_result();
        check("t4_res_data", 32'(res_data), 32'h0000FFE2);
        for (int i = 0; i < 5; i++) begin
            cyc_wait();
            check($sformatf("t4_hold_valid%0d", i), 32'(res_valid), 32'd1);
            check($sformatf("t4_hold_data%0d", i), 32'(res_data), 32'h0000FFE2);
        end
        check("t4_busy_held", 32'(busy), 32'd1);
        finish_result();

        // zero-length start is ignored
        cfg_len = 8'd0; cfg_seed_en = 1'b0; cfg_seed = '0;
        start = 1'b1;
        cyc_wait();
        start = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_op_ready", 32'(op_ready), 32'd0);
        cyc_wait();
        check("t5_busy2", 32'(busy), 32'd0);

        // reset after beat 1 of a len=4 job, then a fresh job on the first edge after release
        clear_log();
        start_job(8'd4, 1'b1, 32'd50);
        send_beat(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
        send_beat(16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2);
        check("t6_pre_busy", 32'(busy), 32'd1);
        arst_in = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_op_ready", 32'(op_ready), 32'd0);
        check("t6_rst_miv", 32'(mac_input_valid), 32'd0);
        check("t6_rst_acc_int", 32'(mac_accumulate_internal), 32'd0);
        check("t6_rst_mac_a0", 32'(mac_a0), 32'd0);
        check("t6_rst_psum", mac_partial_sum_in, 32'd0);
        check("t6_rst_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        clear_log();
        rv_before = rv_count;
        arst_in = 1'b0;
        start_job(8'd1, 1'b0, 32'd0);
        check("t7_accept_first_edge", 32'(busy), 32'd1);
        send_beat(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
        wait_result();
        check("t7_res_data", 32'(res_data), 32'd3);
        check("t7_single_result", 32'(rv_count - rv_before), 32'd1);
        finish_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac3_driver.md
MAC3_DRIVER -- requirements
Module: mac3_driver

Interface
REQ-001 SHALL have parameter A_WIDTH, default 16, operand a width.
REQ-002 SHALL have parameter B_WIDTH, default 16, operand b width.
REQ-003 SHALL have parameter ACCUMULATOR_WIDTH, default 32, partial-sum width.
REQ-004 SHALL have parameter OUTPUT_WIDTH, default 16, result width.
REQ-005 SHALL have parameter CNT_WIDTH, default 8, beat-count width.
REQ-006 SHALL have ports, in this order:
- clk  in  1  single clock; all state changes on rising edge.
- arst_in  in  1  reset, asynchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- cfg_len  in  CNT_WIDTH  number of operand beats in the job.
- cfg_seed_en  in  1  1: first beat adds cfg_seed; 0: first beat adds 0.
- cfg_seed  in  ACCUMULATOR_WIDTH  signed seed partial sum.
- op_valid / op_ready  in / out  1  operand-stream handshake.
- op_a0, op_a1, op_a2  in  A_WIDTH each  signed operands.
- op_b0, op_b1, op_b2  in  B_WIDTH each  signed operands.
- mac_input_valid  out  1  drives the MAC write enable.
- mac_accumulate_internal  out  1  drives the MAC accumulate select.
- mac_partial_sum_in  out  ACCUMULATOR_WIDTH  drives the MAC partial-sum input.
- mac_a0..mac_a2, mac_b0..mac_b2  out  A_WIDTH/B_WIDTH  registered operands to the MAC.
- mac_out  in  OUTPUT_WIDTH  scaled MAC accumulator output.
- res_valid / res_ready  out / in  1  result handshake.
- res_data  out  OUTPUT_WIDTH  captured job result.
- busy  out  1  high in every state except IDLE.

Function
REQ-007 SHALL implement FSM states IDLE, RUN, DRAIN, CAPTURE, RESULT.
REQ-008 IDLE: op_ready=0; when start=1 and cfg_len!=0, SHALL latch cfg_len, cfg_seed_en and cfg_seed, clear the beat counter, and go to RUN.
REQ-009 start with cfg_len=0 SHALL be ignored; the FSM stays in IDLE and busy stays 0.
REQ-010 start outside IDLE SHALL be ignored; latched config SHALL NOT change.
REQ-011 RUN: op_ready=1.
- Each op_valid&&op_ready SHALL register all six operands onto mac_a*/mac_b*.
- It SHALL set mac_input_valid=1 in the next cycle, with mac_accumulate_internal=0 for beat 0 and 1 for every later beat.
- It SHALL increment the beat counter.
REQ-012 A RUN cycle without a handshake SHALL produce mac_input_valid=0 next cycle; mac_a*/mac_b* and mac_accumulate_internal SHALL hold.
REQ-013 mac_partial_sum_in SHALL equal the latched seed when seed_en=1, else 0, and SHALL be stable for the whole job.
REQ-014 On the handshake of beat latched_len-1, SHALL go to DRAIN; op_ready SHALL be 0 from the next cycle.
REQ-015 DRAIN lasts one cycle, in which the final mac_input_valid=1 pulse is issued. SHALL then go to CAPTURE.
REQ-016 CAPTURE lasts one cycle; SHALL register mac_out into res_data and go to RESULT.
REQ-017 Latency: res_valid SHALL rise exactly 3 cycles after the last operand handshake.
REQ-018 RESULT: res_valid=1 and res_data SHALL hold until res_ready=1. On that handshake, SHALL go to IDLE with res_valid=0 the following cycle.
REQ-019 mac_input_valid SHALL be 0 in IDLE, CAPTURE and RESULT.
REQ-020 The beat counter SHALL be CNT_WIDTH wide. Max job length is 2^CNT_WIDTH-1 beats; no wrap occurs within a job.

Reset
REQ-021 arst_in=1 SHALL immediately force IDLE. busy, op_ready, mac_input_valid, mac_accumulate_internal and res_valid SHALL go to 0. All data outputs, the counter and latched config SHALL go to 0.
REQ-022 Reset mid-job SHALL discard the job; no res_valid SHALL be produced for it after release.
REQ-023 After release, the first start SHALL be accepted on the first rising edge with arst_in=0.

Verification
REQ-024 The bench SHALL pair the DUT with a behavioural 3-MAC model, OUTPUT_SCALE=0, and cover:
- len=1, seed_en=0, a=(1,2,3), b=(4,5,6) -> one mac_input_valid pulse with accumulate_internal=0, partial_sum_in=0; res_data=32, res_valid 3 cycles after the handshake.
- len=1, seed_en=1, seed=100, a=(2,0,0), b=(3,0,0) -> res_data=106.
- len=3, all operands 1, op_valid low 2 cycles between beats -> mac_input_valid pulses only on handshakes, accumulate_internal pattern 0,1,1; res_data=9.
- len=2, a=(-1,-1,-1), b=(5,5,5), res_ready held low 5 cycles -> res_data=-30 held stable with res_valid=1; busy drops after the handshake.
- start with cfg_len=0 -> busy stays 0, op_ready stays 0; start during RUN -> no effect on the job.
- arst_in pulse after beat 1 of len=4 -> all outputs 0 immediately; no res_valid afterwards; next job len=1, a=(1,1,1), b=(1,1,1) -> res_data=3.
